// File: rtl/sfu_seq_if.sv
// Command, psum-SRAM read, SFU control and output-SRAM write signals of the
// SFU sequencer, bundled so the block and its host share one port list.
interface sfu_seq_if #(
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 4
);
  logic               start_i;
  logic [1:0]         mode_i;
  logic [cnt_bw-1:0]  win_len_i;
  logic [cnt_bw-1:0]  num_grp_i;
  logic [addr_bw-1:0] rd_base_i;
  logic [addr_bw-1:0] wr_base_i;
  logic               rd_en_o;
  logic [addr_bw-1:0] rd_addr_o;
  logic               acc_o;
  logic               max_pool_en_o;
  logic               psum_bypass_o;
  logic               wr_en_o;
  logic [addr_bw-1:0] wr_addr_o;
  logic               busy_o;
  logic               done_o;

  // Host side: issues commands, observes the sequencer.
  modport master (
    output start_i, mode_i, win_len_i, num_grp_i, rd_base_i, wr_base_i,
    input  rd_en_o, rd_addr_o, acc_o, max_pool_en_o, psum_bypass_o,
           wr_en_o, wr_addr_o, busy_o, done_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, mode_i, win_len_i, num_grp_i, rd_base_i, wr_base_i,
    output rd_en_o, rd_addr_o, acc_o, max_pool_en_o, psum_bypass_o,
           wr_en_o, wr_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/sfu_seq.sv
// SFU sequencer: walks G windows of N psums through the psum SRAM, drives the
// SFU accumulate / max-pool / bypass controls aligned with the 1-cycle SRAM
// read latency, and writes the SFU results to consecutive output addresses.
//
// Timing from the accepting edge (edge 0):
//   mode 1      : first read on edge 0, one gap/write slot per window,
//                 done_o at G*(N+1)+1.
//   mode 2      : first read on edge 1, one gap between windows,
//                 done_o at G*(N+1)+1.
//   modes 0 / 3 : first read on edge 1, back-to-back reads,
//                 done_o at G*N+2.
// Mode 1 issues its first read straight out of IDLE because its extra
// per-window write slot would otherwise push completion one cycle later.
module sfu_seq #(
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 4
) (
  input  logic     clk,
  input  logic     reset,
  sfu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_RELU = 2'd0;
  localparam logic [1:0] MODE_ACC  = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;
  localparam logic [1:0] MODE_BYP  = 2'd3;

  // A zero-length field means one.
  function automatic logic [cnt_bw-1:0] at_least_one(input logic [cnt_bw-1:0] v);
    return (v == '0) ? cnt_bw'(1) : v;
  endfunction

  state_t state_q, state_d;

  // Latched command fields and walk counters.
  logic [1:0]         mode_q;
  logic [cnt_bw-1:0]  win_q, grp_q;
  logic [addr_bw-1:0] rd_base_q;
  logic [cnt_bw-1:0]  elem_q, gidx_q;
  logic [addr_bw-1:0] rd_cnt_q;

  // Issue-stage view: command inputs while accepting, latched fields otherwise.
  logic               idle, accept;
  logic [1:0]         mode_c;
  logic [cnt_bw-1:0]  win_c, grp_c, elem_c, gidx_c;
  logic [addr_bw-1:0] base_c, rd_cnt_c;
  logic               issue, last_e, last_g, pair_mode, wr_fin;

  // Registered outputs and pipeline tags.
  logic               rd_en_q, acc_q, mp_q, byp_q, wr_en_q, busy_q, done_q;
  logic [addr_bw-1:0] rd_addr_q, wr_addr_q;
  logic               vld_p0, lastg_p0, lasta_p0;
  logic               vld_p1, lastg_p1, lasta_p1;
  logic               wr_last_q;

  // Next values for the registered outputs and counters.
  logic               rd_en_d, acc_d, mp_d, byp_d, wr_en_d, busy_d, done_d;
  logic [addr_bw-1:0] rd_addr_d, wr_addr_d;
  logic               vld_p0_d, lastg_p0_d, lasta_p0_d, wr_last_d;
  logic [cnt_bw-1:0]  elem_nx, gidx_nx;
  logic [addr_bw-1:0] rd_cnt_nx;

  assign idle      = (state_q == S_IDLE);
  assign accept    = idle && bus.start_i;
  assign mode_c    = idle ? bus.mode_i                 : mode_q;
  assign win_c     = idle ? at_least_one(bus.win_len_i) : win_q;
  assign grp_c     = idle ? at_least_one(bus.num_grp_i) : grp_q;
  assign base_c    = idle ? bus.rd_base_i              : rd_base_q;
  assign elem_c    = idle ? '0 : elem_q;
  assign gidx_c    = idle ? '0 : gidx_q;
  assign rd_cnt_c  = idle ? '0 : rd_cnt_q;
  assign issue     = (state_q == S_ISSUE) || (accept && (bus.mode_i == MODE_ACC));
  assign last_e    = (elem_c == win_c - cnt_bw'(1));
  assign last_g    = (gidx_c == grp_c - cnt_bw'(1));
  assign pair_mode = (mode_c == MODE_ACC) || (mode_c == MODE_MAX);
  assign wr_fin    = wr_en_q && wr_last_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a window boundary in modes 1/2 costs one GAP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.mode_i != MODE_ACC)  state_d = S_ISSUE;
          else if (last_e && last_g)   state_d = S_DRAIN;
          else if (last_e)             state_d = S_GAP;
          else                         state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (last_e && last_g)          state_d = S_DRAIN;
        else if (last_e && pair_mode)  state_d = S_GAP;
        else                           state_d = S_ISSUE;
      end
      S_GAP:   state_d = S_ISSUE;
      S_DRAIN: if (wr_fin) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of every registered output and counter.
  always_comb begin
    // issue stage -> p0 (read request on the SRAM port)
    rd_en_d    = issue;
    rd_addr_d  = issue ? base_c + rd_cnt_c : '0;
    vld_p0_d   = issue;
    lastg_p0_d = issue && last_e;
    lasta_p0_d = issue && last_e && last_g;
    rd_cnt_nx  = issue ? rd_cnt_c + addr_bw'(1) : rd_cnt_c;
    elem_nx    = elem_c;
    gidx_nx    = gidx_c;
    if (issue) begin
      if (last_e) begin
        elem_nx = '0;
        gidx_nx = gidx_c + cnt_bw'(1);
      end else begin
        elem_nx = elem_c + cnt_bw'(1);
      end
    end

    // p0 -> p1 (read data at SFU psum_in), p1 -> p2 (mode 1 write slot)
    acc_d     = vld_p0 && (mode_q == MODE_ACC);
    mp_d      = vld_p0 && !lastg_p0 && (mode_q == MODE_MAX);
    wr_en_d   = 1'b0;
    wr_last_d = 1'b0;
    case (mode_q)
      MODE_ACC: begin
        wr_en_d   = vld_p1 && lastg_p1;
        wr_last_d = vld_p1 && lasta_p1;
      end
      MODE_MAX: begin
        wr_en_d   = vld_p0 && lastg_p0;
        wr_last_d = vld_p0 && lasta_p0;
      end
      MODE_RELU, MODE_BYP: begin
        wr_en_d   = vld_p0;
        wr_last_d = vld_p0 && lasta_p0;
      end
      default: ;
    endcase
    if (accept)       wr_addr_d = bus.wr_base_i;
    else if (wr_en_q) wr_addr_d = wr_addr_q + addr_bw'(1);
    else              wr_addr_d = wr_addr_q;

    // command status
    busy_d = (state_d != S_IDLE);
    byp_d  = (state_d != S_IDLE) && (mode_c == MODE_BYP);
    done_d = wr_fin;
  end

  // Command latch, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= '0;
      win_q     <= '0;
      grp_q     <= '0;
      rd_base_q <= '0;
      elem_q    <= '0;
      gidx_q    <= '0;
      rd_cnt_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      vld_p0    <= 1'b0;
      lastg_p0  <= 1'b0;
      lasta_p0  <= 1'b0;
      vld_p1    <= 1'b0;
      lastg_p1  <= 1'b0;
      lasta_p1  <= 1'b0;
      acc_q     <= 1'b0;
      mp_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_last_q <= 1'b0;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      byp_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (accept) begin
        mode_q    <= bus.mode_i;
        win_q     <= at_least_one(bus.win_len_i);
        grp_q     <= at_least_one(bus.num_grp_i);
        rd_base_q <= bus.rd_base_i;
      end
      elem_q    <= elem_nx;
      gidx_q    <= gidx_nx;
      rd_cnt_q  <= rd_cnt_nx;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      vld_p0    <= vld_p0_d;
      lastg_p0  <= lastg_p0_d;
      lasta_p0  <= lasta_p0_d;
      vld_p1    <= vld_p0;
      lastg_p1  <= lastg_p0;
      lasta_p1  <= lasta_p0;
      acc_q     <= acc_d;
      mp_q      <= mp_d;
      wr_en_q   <= wr_en_d;
      wr_last_q <= wr_last_d;
      wr_addr_q <= wr_addr_d;
      busy_q    <= busy_d;
      byp_q     <= byp_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_en_o       = rd_en_q;
  assign bus.rd_addr_o     = rd_addr_q;
  assign bus.acc_o         = acc_q;
  assign bus.max_pool_en_o = mp_q;
  assign bus.psum_bypass_o = byp_q;
  assign bus.wr_en_o       = wr_en_q;
  assign bus.wr_addr_o     = wr_addr_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

endmodule

// File: tb/tb_sfu_seq.sv
// Bench for sfu_seq: a cycle schedule derived from the window/group timing
// rules, plus a small psum SRAM and SFU stand-in whose written results are
// compared with window sums / maxima computed directly from memory.
module tb_sfu_seq;
  localparam int AW = 11;
  localparam int CW = 4;
  localparam int AMASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sfu_seq_if #(.addr_bw(AW), .cnt_bw(CW)) bus();
  sfu_seq #(.addr_bw(AW), .cnt_bw(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // psum SRAM and SFU stand-in
  logic signed [15:0] mem [0:AMASK];
  int psum_in;
  int run;
  bit run_vld;
  int cmd_mode;
  int wq[$];

  function automatic int relu(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  function automatic int sfu_out();
    case (cmd_mode)
      1:       return relu(run);
      2:       return relu(run_vld ? ((psum_in > run) ? psum_in : run) : psum_in);
      3:       return psum_in;
      default: return relu(psum_in);
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      psum_in <= 0;
      run     <= 0;
      run_vld <= 1'b0;
    end else begin
      if (bus.wr_en_o) begin
        wq.push_back(sfu_out());
        run_vld <= 1'b0;
      end else if (bus.acc_o) begin
        run     <= run_vld ? run + psum_in : psum_in;
        run_vld <= 1'b1;
      end else if (bus.max_pool_en_o) begin
        run     <= (run_vld && run > psum_in) ? run : psum_in;
        run_vld <= 1'b1;
      end
      psum_in <= bus.rd_en_o ? int'(mem[bus.rd_addr_o]) : 0;
    end
  end

  function automatic longint ctl_now();
    return longint'({bus.rd_en_o, bus.acc_o, bus.max_pool_en_o, bus.psum_bypass_o,
                     bus.wr_en_o, bus.busy_o, bus.done_o});
  endfunction

  function automatic longint all_outs();
    return longint'({bus.rd_en_o, bus.rd_addr_o, bus.acc_o, bus.max_pool_en_o,
                     bus.psum_bypass_o, bus.wr_en_o, bus.wr_addr_o, bus.busy_o, bus.done_o});
  endfunction

  task automatic drive_cmd(input int mode, input int win, input int grp, input int rb, input int wb);
    bus.start_i   = 1'b1;
    bus.mode_i    = 2'(mode);
    bus.win_len_i = CW'(win);
    bus.num_grp_i = CW'(grp);
    bus.rd_base_i = AW'(rb);
    bus.wr_base_i = AW'(wb);
  endtask

  // Runs one command; xs_k >= 0 pulses a stray start after sample k.
  task automatic run_cmd(input int mode, input int win, input int grp,
                         input int rb, input int wb, input int xs_k);
    int n, gg, t0, per, lat, t, a, v;
    int e_ctl[0:255];
    int e_rda[0:255];
    int e_wra[0:255];
    int ev[$];
    n   = (win == 0) ? 1 : win;
    gg  = (grp == 0) ? 1 : grp;
    lat = (mode == 1 || mode == 2) ? gg * (n + 1) + 1 : gg * n + 2;
    t0  = (mode == 1) ? 0 : 1;
    per = (mode == 1 || mode == 2) ? n + 1 : n;
    for (int k = 0; k < 256; k++) begin
      e_ctl[k] = 0; e_rda[k] = 0; e_wra[k] = 0;
    end
    // bits: rd=64 acc=32 mp=16 byp=8 wr=4 busy=2 done=1
    for (int k = 0; k <= lat; k++) e_ctl[k] = 2 | ((mode == 3) ? 8 : 0);
    e_ctl[lat] |= 1;
    for (int g = 0; g < gg; g++) begin
      for (int e = 0; e < n; e++) begin
        t = t0 + g * per + e;
        a = t + 1;
        e_ctl[t] |= 64;
        e_rda[t] = (rb + g * n + e) & AMASK;
        case (mode)
          1: begin
            e_ctl[a] |= 32;
            if (e == n - 1) begin
              e_ctl[a + 1] |= 4;
              e_wra[a + 1] = (wb + g) & AMASK;
            end
          end
          2: begin
            if (e < n - 1) e_ctl[a] |= 16;
            else begin
              e_ctl[a] |= 4;
              e_wra[a] = (wb + g) & AMASK;
            end
          end
          default: begin
            e_ctl[a] |= 4;
            e_wra[a] = (wb + g * n + e) & AMASK;
          end
        endcase
      end
      // expected SFU results straight from memory
      if (mode == 1 || mode == 2) begin
        v = int'(mem[(rb + g * n) & AMASK]);
        for (int e = 1; e < n; e++) begin
          if (mode == 1) v = v + int'(mem[(rb + g * n + e) & AMASK]);
          else if (int'(mem[(rb + g * n + e) & AMASK]) > v) v = int'(mem[(rb + g * n + e) & AMASK]);
        end
        ev.push_back(relu(v));
      end else begin
        for (int e = 0; e < n; e++) begin
          v = int'(mem[(rb + g * n + e) & AMASK]);
          ev.push_back((mode == 3) ? v : relu(v));
        end
      end
    end

    cmd_mode = mode;
    wq.delete();
    @(negedge clk);
    drive_cmd(mode, win, grp, rb, wb);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      check($sformatf("m%0d ctl k%0d", mode, k), ctl_now(), e_ctl[k]);
      if ((e_ctl[k] & 64) != 0) check($sformatf("m%0d rd_addr k%0d", mode, k), bus.rd_addr_o, e_rda[k]);
      if ((e_ctl[k] & 4) != 0)  check($sformatf("m%0d wr_addr k%0d", mode, k), bus.wr_addr_o, e_wra[k]);
      if (k == xs_k) drive_cmd($urandom_range(0, 3), 1, 1, 0, 0);
    end
    bus.start_i = 1'b0;
    check($sformatf("m%0d n_writes", mode), wq.size(), ev.size());
    for (int i = 0; i < ev.size(); i++)
      check($sformatf("m%0d wdata%0d", mode, i), (i < wq.size()) ? wq[i] : -99999, ev[i]);
  endtask

  task automatic abort_test();
    cmd_mode = 1;
    wq.delete();
    @(negedge clk);
    drive_cmd(1, 3, 2, 'h100, 'h20);
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    @(negedge clk);
    check("abort first read", {bus.rd_en_o, bus.rd_addr_o}, {1'b1, 11'h100});
    drive_cmd(0, 5, 5, 'h500, 'h600);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("abort second read", {bus.rd_en_o, bus.rd_addr_o}, {1'b1, 11'h101});
    reset = 1'b1;
    @(negedge clk);
    check("abort outs zero", all_outs(), 0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("abort quiet k%0d", k), ctl_now(), 0);
    end
    check("abort no writes", wq.size(), 0);
  endtask

  initial begin
    int md, wl, ng;
    reset         = 1'b1;
    bus.start_i   = 1'b0;
    bus.mode_i    = '0;
    bus.win_len_i = '0;
    bus.num_grp_i = '0;
    bus.rd_base_i = '0;
    bus.wr_base_i = '0;
    for (int i = 0; i <= AMASK; i++) mem[i] = 16'($urandom_range(0, 200) - 100);
    repeat (3) @(negedge clk);
    check("reset outs", all_outs(), 0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(1, 3, 2, 'h000, 'h010, -1);
    mem['h40] = 16'sd5; mem['h41] = -16'sd2; mem['h42] = 16'sd9; mem['h43] = 16'sd1;
    run_cmd(2, 4, 1, 'h040, 'h200, -1);
    check("maxpool value", (wq.size() > 0) ? wq[0] : -99999, 9);
    run_cmd(3, 2, 3, 'h7FE, 'h300, -1);
    run_cmd(1, 0, 0, 'h055, 'h066, -1);
    run_cmd(2, 1, 3, 'h120, 'h7FF, -1);
    run_cmd(0, 4, 2, 'h180, 'h400, 2);
    run_cmd(1, 2, 3, 'h1A0, 'h410, 4);
    abort_test();
    run_cmd(1, 3, 2, 'h000, 'h010, -1);

    for (int r = 0; r < 20; r++) begin
      md = $urandom_range(0, 3);
      wl = $urandom_range(0, 6);
      ng = $urandom_range(0, 4);
      run_cmd(md, wl, ng, $urandom_range(0, AMASK), $urandom_range(0, AMASK), -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/sfu_seq.md
SFU_SEQ -- requirements
Module: sfu_seq

Interface
REQ-001 The block SHALL have parameter addr_bw, default 11, meaning the width of the psum SRAM read and write addresses.
REQ-002 The block SHALL have parameter cnt_bw, default 4, meaning the width of the window-length and group-count fields.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start_i  in  1  one-cycle command strobe; sampled in IDLE only.
- mode_i  in  2  0 relu-only, 1 accumulate+relu, 2 maxpool+relu, 3 bypass.
- win_len_i  in  cnt_bw  psums per output (N); 0 is treated as 1.
- num_grp_i  in  cnt_bw  number of outputs (G); 0 is treated as 1.
- rd_base_i  in  addr_bw  first read address.
- wr_base_i  in  addr_bw  first write address.
- rd_en_o  out  1  psum SRAM read enable; data returns 1 cycle later.
- rd_addr_o  out  addr_bw  psum SRAM read address.
- acc_o  out  1  to SFU accumulate control.
- max_pool_en_o  out  1  to SFU max-pool control.
- psum_bypass_o  out  1  to SFU bypass control.
- wr_en_o  out  1  output SRAM write enable; data is SFU psum_out in the same cycle.
- wr_addr_o  out  addr_bw  output SRAM write address.
- busy_o  out  1  high from the cycle after accepted start until done.
- done_o  out  1  one-cycle pulse after the final write.
REQ-004 Reset SHALL be synchronous and active-high; one clock only.

Function
REQ-005 States SHALL be IDLE, ISSUE, GAP, DRAIN, DONE.
REQ-006 In IDLE, start_i=1 SHALL latch all command fields, clear the read, element and group counters, and go to ISSUE; start_i outside IDLE SHALL be ignored.
REQ-007 In ISSUE, rd_en_o SHALL be 1 each cycle, and rd_addr_o SHALL be rd_base + (g*N + e), wrapping modulo 2^addr_bw.
REQ-008 Control for data read in cycle t SHALL be driven in cycle t+1, when that data is at SFU psum_in.
REQ-009 Mode 1: acc_o SHALL be 1 in the N cycles in which elements 0..N-1 arrive, then 0 for the following cycle, in which wr_en_o SHALL be 1 and no read data is presented.
REQ-010 Mode 2: max_pool_en_o SHALL be 1 while elements 0..N-2 arrive and 0 while element N-1 arrives, with wr_en_o=1 in that same cycle.
REQ-011 Mode 2 with N=1: max_pool_en_o SHALL stay 0 and the element SHALL be written as relu-only.
REQ-012 Mode 0 and mode 3: each element SHALL produce one write in its arrival cycle; G*N total writes.
- acc_o and max_pool_en_o SHALL be 0.
- psum_bypass_o SHALL be 1 only in mode 3, held for the whole command.
REQ-013 wr_addr_o SHALL start at wr_base and increment by 1 after each write, wrapping modulo 2^addr_bw.
REQ-014 After the last read of a group, in modes 1 and 2, ISSUE SHALL enter GAP for exactly one cycle, with rd_en_o=0, before the next group's first read.
- This guarantees a low cycle on acc_o/max_pool_en_o between windows.
- Modes 0 and 3 SHALL read back-to-back with no GAP.
REQ-015 After the final read, the FSM SHALL enter DRAIN until the final write has been issued, then DONE for one cycle with done_o=1, then IDLE.
REQ-016 Total latency SHALL be:
- Mode 1: G*(N+1)+1 cycles from start to done_o.
- Mode 2: G*(N+1)+1 cycles from start to done_o.
- Modes 0 and 3: G*N+2 cycles from start to done_o.
REQ-017 Outputs SHALL be registered, except that the SFU controls are aligned to the SRAM 1-cycle latency as in REQ-008.

Reset
REQ-018 While reset=1:
- All outputs SHALL be 0 on the next edge.
- The FSM SHALL be in IDLE.
- All counters and latched fields SHALL be cleared.
REQ-019 Reset asserted mid-command SHALL abort it with no further reads or writes and no done_o pulse.
REQ-020 After reset, the first start_i SHALL be accepted normally.

Verification
REQ-021 Mode 1, N=3, G=2, rd_base=0, wr_base=0x10: reads 0,1,2,gap,3,4,5 -> acc_o high 3 cycles twice; writes to 0x10 and 0x11 only; done_o 9 cycles after start.
REQ-022 Mode 2, N=4, G=1, SFU-model inputs {5,-2,9,1}: max_pool_en_o high 3 cycles -> single write of 9 with max_pool_en_o=0 in the write cycle.
REQ-023 Mode 3, N=2, G=3, rd_base=0x7FE (addr_bw=11) -> read addresses 0x7FE,0x7FF,0x000..0x003; 6 writes; psum_bypass_o=1 throughout.
REQ-024 win_len_i=0, num_grp_i=0, mode 1 -> behaves as N=1, G=1: one read, one write, done_o at cycle 3.
REQ-025 start_i pulsed while busy_o=1, and reset asserted at the second read of a mode 1 command -> the extra start is ignored; after reset all outputs are 0, no done_o pulse, and a fresh start completes correctly.
